// File: rtl/hgcal_input_packer_pkg.sv
// Shared HGCAL input-packer definitions: default geometry, FSM state
// encoding and a small saturating-counter helper.
package hgcal_input_packer_pkg;

   localparam int HGCAL_N_FEAT    = 48;
   localparam int HGCAL_BW        = 2;
   localparam int HGCAL_BEAT_FEAT = 4;

   localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

   typedef enum logic [1:0] {
      ST_FILL = 2'd0,
      ST_HOLD = 2'd1,
      ST_DROP = 2'd2
   } pack_state_t;

   function automatic logic [7:0] satInc8(input logic [7:0] value);
      return (value == ERR_CNT_MAX) ? value : value + 8'd1;
   endfunction

endpackage

// File: rtl/hgcal_input_packer_vec_reg.sv
// Output vector register with valid/ready handshake. Holds data and valid
// stable while the consumer stalls, and can take a new vector on the same
// edge the current one is handed off.
module hgcal_vec_reg #(
   parameter int W = 96
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [W-1:0] i_data,
   output logic         o_can_load,
   output logic [W-1:0] o_data,
   output logic         o_valid,
   input  logic         i_ready
);

   logic [W-1:0] r_data;
   logic         r_valid;
   logic         w_can_load;

   assign w_can_load = !r_valid || i_ready;
   assign o_can_load = w_can_load;
   assign o_data     = r_data;
   assign o_valid    = r_valid;

   // Load a new vector when the slot is free or being drained this cycle;
   // otherwise drop valid once the consumer has taken the current vector.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else if (i_load && w_can_load) begin
         r_data  <= i_data;
         r_valid <= 1'b1;
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/hgcal_input_packer.sv
// Packs narrow beats of quantized feature codes into one wide vector for the
// layer-0 fan-in. Framing is checked against s_last; bad frames are dropped
// and counted. A completed vector waits in the assembly register (HOLD) when
// the output register is busy.
module hgcal_input_packer
   import hgcal_input_packer_pkg::*;
#(
   parameter int N_FEAT    = HGCAL_N_FEAT,
   parameter int BW        = HGCAL_BW,
   parameter int BEAT_FEAT = HGCAL_BEAT_FEAT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [BEAT_FEAT*BW-1:0] s_data,
   input  logic                    s_valid,
   input  logic                    s_last,
   output logic                    s_ready,
   output logic [N_FEAT*BW-1:0]    m_data,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic                    frame_err,
   output logic [7:0]              err_cnt
);

   localparam int BEAT_W = BEAT_FEAT * BW;
   localparam int VEC_W  = N_FEAT * BW;
   localparam int BEATS  = N_FEAT / BEAT_FEAT;
   localparam int CW     = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

   generate
      if ((N_FEAT % BEAT_FEAT) != 0) begin : g_bad_geometry
         $error("hgcal_input_packer: N_FEAT must be a multiple of BEAT_FEAT");
      end
   endgenerate

   pack_state_t        r_state;
   pack_state_t        w_next_state;
   logic [CW-1:0]      r_beat_cnt;
   logic [VEC_W-1:0]   r_assembly;
   logic [VEC_W-1:0]   w_vec_merged;
   logic [VEC_W-1:0]   w_load_data;
   logic               r_frame_err;
   logic [7:0]         r_err_cnt;

   logic w_s_ready;
   logic w_accept;
   logic w_at_last;
   logic w_complete;
   logic w_short_err;
   logic w_long_err;
   logic w_err;
   logic w_load_req;
   logic w_can_load;

   assign w_accept  = s_valid && w_s_ready;
   assign w_at_last = (r_beat_cnt == LAST_BEAT);

   // Current assembly with the incoming beat dropped into its slot; used both
   // to update the assembly register and as the vector loaded on completion.
   always_comb begin
      w_vec_merged = r_assembly;
      w_vec_merged[int'(r_beat_cnt) * BEAT_W +: BEAT_W] = s_data;
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_FILL;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic: stall into HOLD when a finished vector cannot reach
   // the output register, and swallow the rest of an overlong frame in DROP.
   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         ST_FILL: begin
            if (w_complete && !w_can_load) begin
               w_next_state = ST_HOLD;
            end else if (w_long_err) begin
               w_next_state = ST_DROP;
            end
         end
         ST_HOLD: begin
            if (w_can_load) begin
               w_next_state = ST_FILL;
            end
         end
         ST_DROP: begin
            if (w_accept && s_last) begin
               w_next_state = ST_FILL;
            end
         end
         default: w_next_state = ST_FILL;
      endcase
   end

   // Output decode: upstream ready, frame classification and the load
   // request toward the output register.
   always_comb begin
      w_s_ready   = rst && (r_state != ST_HOLD);
      w_complete  = (r_state == ST_FILL) && w_accept && w_at_last && s_last;
      w_short_err = (r_state == ST_FILL) && w_accept && !w_at_last && s_last;
      w_long_err  = (r_state == ST_FILL) && w_accept && w_at_last && !s_last;
      w_err       = w_short_err || w_long_err;
      w_load_req  = w_complete || (r_state == ST_HOLD);
      w_load_data = (r_state == ST_HOLD) ? r_assembly : w_vec_merged;
   end

   // Beat counter: advances per accepted beat in FILL and restarts at zero
   // whenever a frame ends, cleanly or not.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_beat_cnt <= '0;
      end else if ((r_state == ST_FILL) && w_accept) begin
         if (w_complete || w_err) begin
            r_beat_cnt <= '0;
         end else begin
            r_beat_cnt <= r_beat_cnt + CW'(1);
         end
      end
   end

   // Assembly register: captures every beat accepted in FILL, including the
   // final one so a stalled vector can be replayed from here out of HOLD.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_assembly <= '0;
      end else if ((r_state == ST_FILL) && w_accept) begin
         r_assembly <= w_vec_merged;
      end
   end

   // Framing error pulse and saturating error count, updated together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_frame_err <= 1'b0;
         r_err_cnt   <= 8'd0;
      end else begin
         r_frame_err <= w_err;
         if (w_err) begin
            r_err_cnt <= satInc8(r_err_cnt);
         end
      end
   end

   hgcal_vec_reg #(
      .W (VEC_W)
   ) u_vec_reg (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load_req),
      .i_data     (w_load_data),
      .o_can_load (w_can_load),
      .o_data     (m_data),
      .o_valid    (m_valid),
      .i_ready    (m_ready)
   );

   assign s_ready   = w_s_ready;
   assign frame_err = r_frame_err;
   assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_hgcal_input_packer.sv
// Self-checking bench for hgcal_input_packer. A frame-level model tracks the
// partial frame, a drop flag and a queue of vectors still inside the DUT;
// at most two vectors fit (output register plus the stalled one), which
// predicts s_ready and m_valid without mirroring the FSM.
module tb_hgcal_input_packer;

   localparam int BEATS = 12;
   localparam int VEC_W = 96;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [7:0]        s_data = 8'h00;
   logic              s_valid = 1'b0;
   logic              s_last = 1'b0;
   logic              s_ready;
   logic [VEC_W-1:0]  m_data;
   logic              m_valid;
   logic              m_ready = 1'b0;
   logic              frame_err;
   logic [7:0]        err_cnt;

   int checks = 0;
   int errors = 0;

   logic [VEC_W-1:0] modelQ[$];
   logic [VEC_W-1:0] modelPart;
   int               modelLen;
   bit               modelDropping;
   bit               modelFrameErr;
   int               modelErrCnt;

   hgcal_input_packer dut (
      .clk       (clk),
      .rst       (rst),
      .s_data    (s_data),
      .s_valid   (s_valid),
      .s_last    (s_last),
      .s_ready   (s_ready),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .frame_err (frame_err),
      .err_cnt   (err_cnt)
   );

   // Free-running 100 MHz clock.
   initial begin
      forever #5 clk = ~clk;
   end

   function automatic bit expReady();
      return (rst == 1'b1) && (modelQ.size() < 2);
   endfunction

   task automatic clearModel();
      modelQ.delete();
      modelPart     = '0;
      modelLen      = 0;
      modelDropping = 1'b0;
      modelFrameErr = 1'b0;
      modelErrCnt   = 0;
   endtask

   // Drive one cycle of inputs, advance the model across the edge, then
   // leave time at posedge+1 so callers sample settled outputs.
   task automatic applyStimulus(input bit v, input bit l, input logic [7:0] d, input bit mr);
      bit rdy;
      bit hs;
      bit err;
      s_valid = v;
      s_last  = l;
      s_data  = d;
      m_ready = mr;
      rdy = expReady();
      hs  = (modelQ.size() > 0) && mr;
      @(posedge clk);
      err = 1'b0;
      if (hs) void'(modelQ.pop_front());
      if (v && rdy) begin
         if (modelDropping) begin
            if (l) modelDropping = 1'b0;
         end else begin
            modelPart = modelPart | (VEC_W'(d) << (modelLen * 8));
            modelLen++;
            if (l) begin
               if (modelLen == BEATS) modelQ.push_back(modelPart);
               else err = 1'b1;
               modelPart = '0;
               modelLen  = 0;
            end else if (modelLen == BEATS) begin
               err           = 1'b1;
               modelDropping = 1'b1;
               modelPart     = '0;
               modelLen      = 0;
            end
         end
      end
      modelFrameErr = err;
      if (err && modelErrCnt < 255) modelErrCnt++;
      #1;
   endtask

   task automatic feed(input int n, input bit lastOnFinal, input bit mr);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b1, lastOnFinal && (i == n - 1), 8'($urandom), mr);
      end
   endtask

   task automatic enterReset();
      rst     = 1'b0;
      s_valid = 1'b0;
      s_last  = 1'b0;
      m_ready = 1'b0;
      clearModel();
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic leaveReset();
      #2 rst = 1'b1;
   endtask

   task automatic test_reset();
      enterReset();
      checks++; if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_s_ready: got %b expected 0", s_ready); end
      checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_valid: got %b expected 0", m_valid); end
      checks++; if (m_data !== '0) begin errors++; $display("[TB] FAIL reset_m_data: got %h expected 0", m_data); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err); end
      checks++; if (err_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
      leaveReset();
      #1;
      checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_s_ready: got %b expected 1", s_ready); end
   endtask

   task automatic test_single_vector();
      logic [VEC_W-1:0] expVec;
      expVec = {12{8'hE4}};
      for (int i = 0; i < BEATS; i++) begin
         applyStimulus(1'b1, i == BEATS - 1, 8'hE4, 1'b1);
         if (i == BEATS - 2) begin
            checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_early_valid: got %b expected 0", m_valid); end
         end
      end
      checks++; if (m_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_latency: got %b expected 1", m_valid); end
      checks++; if (m_data !== expVec) begin errors++; $display("[TB] FAIL single_data: got %h expected %h", m_data, expVec); end
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_clear: got %b expected 0", m_valid); end
   endtask

   task automatic test_back_to_back();
      int delivered = 0;
      for (int i = 0; i < 3 * BEATS; i++) begin
         if (m_valid === 1'b1) delivered++;
         applyStimulus(1'b1, (i % BEATS) == BEATS - 1, 8'($urandom), 1'b1);
         checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_s_ready: cycle %0d got %b expected 1", i, s_ready); end
         if (modelQ.size() > 0) begin
            checks++; if (m_valid !== 1'b1 || m_data !== modelQ[0]) begin errors++; $display("[TB] FAIL b2b_vector: got v=%b %h expected %h", m_valid, m_data, modelQ[0]); end
         end
      end
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      if (m_valid === 1'b1) delivered++;
      checks++; if (delivered !== 2) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 2", delivered); end
   endtask

   task automatic test_hold();
      logic [VEC_W-1:0] vec2;
      feed(BEATS, 1'b1, 1'b0);
      feed(BEATS, 1'b1, 1'b0);
      vec2 = modelQ[1];
      checks++; if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_s_ready: got %b expected 0", s_ready); end
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
         checks++; if (m_valid !== 1'b1 || m_data !== modelQ[0] || s_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_stable: got v=%b r=%b %h expected %h", m_valid, s_ready, m_data, modelQ[0]); end
      end
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      checks++; if (m_valid !== 1'b1 || m_data !== vec2) begin errors++; $display("[TB] FAIL hold_vec2: got v=%b %h expected %h", m_valid, m_data, vec2); end
      checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL hold_resume: got %b expected 1", s_ready); end
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_drain: got %b expected 0", m_valid); end
   endtask

   task automatic test_short_frame();
      int startCnt;
      startCnt = modelErrCnt;
      feed(6, 1'b1, 1'b1);
      checks++; if (frame_err !== 1'b1) begin errors++; $display("[TB] FAIL short_pulse: got %b expected 1", frame_err); end
      checks++; if (int'(err_cnt) !== startCnt + 1) begin errors++; $display("[TB] FAIL short_cnt: got %0d expected %0d", err_cnt, startCnt + 1); end
      checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL short_no_valid: got %b expected 0", m_valid); end
      feed(BEATS, 1'b1, 1'b1);
      checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL short_pulse_width: got %b expected 0", frame_err); end
      checks++; if (m_valid !== 1'b1 || m_data !== modelQ[0]) begin errors++; $display("[TB] FAIL short_recover: got v=%b %h expected %h", m_valid, m_data, modelQ[0]); end
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
   endtask

   task automatic test_long_frame();
      int startCnt;
      int pulses = 0;
      startCnt = modelErrCnt;
      feed(BEATS, 1'b0, 1'b1);
      if (frame_err === 1'b1) pulses++;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, i == 2, 8'($urandom), 1'b1);
         if (frame_err === 1'b1) pulses++;
         checks++; if (m_valid !== 1'b0 || s_ready !== 1'b1) begin errors++; $display("[TB] FAIL long_drop: got v=%b r=%b expected v=0 r=1", m_valid, s_ready); end
      end
      checks++; if (pulses !== 1) begin errors++; $display("[TB] FAIL long_pulses: got %0d expected 1", pulses); end
      checks++; if (int'(err_cnt) !== startCnt + 1) begin errors++; $display("[TB] FAIL long_cnt: got %0d expected %0d", err_cnt, startCnt + 1); end
      feed(BEATS, 1'b1, 1'b1);
      checks++; if (m_valid !== 1'b1 || m_data !== modelQ[0]) begin errors++; $display("[TB] FAIL long_recover: got v=%b %h expected %h", m_valid, m_data, modelQ[0]); end
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
   endtask

   task automatic test_reset_mid();
      feed(7, 1'b0, 1'b1);
      enterReset();
      checks++; if (m_valid !== 1'b0 || err_cnt !== 8'd0) begin errors++; $display("[TB] FAIL midrst_outputs: got v=%b cnt=%0d expected 0 0", m_valid, err_cnt); end
      leaveReset();
      feed(BEATS, 1'b1, 1'b1);
      checks++; if (m_valid !== 1'b1 || m_data !== modelQ[0]) begin errors++; $display("[TB] FAIL midrst_vector: got v=%b %h expected %h", m_valid, m_data, modelQ[0]); end
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      feed(BEATS, 1'b1, 1'b0);
      feed(BEATS, 1'b1, 1'b0);
      checks++; if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL holdrst_entered: got %b expected 0", s_ready); end
      enterReset();
      checks++; if (m_valid !== 1'b0 || s_ready !== 1'b0) begin errors++; $display("[TB] FAIL holdrst_outputs: got v=%b r=%b expected 0 0", m_valid, s_ready); end
      leaveReset();
      feed(BEATS, 1'b1, 1'b1);
      checks++; if (m_valid !== 1'b1 || m_data !== modelQ[0]) begin errors++; $display("[TB] FAIL holdrst_vector: got v=%b %h expected %h", m_valid, m_data, modelQ[0]); end
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL holdrst_single: got %b expected 0", m_valid); end
   endtask

   task automatic test_random();
      bit v;
      bit l;
      bit mr;
      for (int i = 0; i < 2000; i++) begin
         v  = ($urandom_range(0, 3) != 0);
         mr = ($urandom_range(0, 2) != 0);
         if (modelDropping)               l = ($urandom_range(0, 2) == 0);
         else if (modelLen == BEATS - 1)  l = ($urandom_range(0, 19) != 0);
         else                             l = ($urandom_range(0, 49) == 0);
         applyStimulus(v, l, 8'($urandom), mr);
         checks++;
         if (s_ready !== expReady() || m_valid !== (modelQ.size() > 0) ||
             (modelQ.size() > 0 && m_data !== modelQ[0]) ||
             frame_err !== modelFrameErr || int'(err_cnt) !== modelErrCnt) begin
            errors++;
            $display("[TB] FAIL random_cycle%0d: got r=%b v=%b fe=%b cnt=%0d expected r=%b v=%b fe=%b cnt=%0d",
                     i, s_ready, m_valid, frame_err, err_cnt, expReady(), modelQ.size() > 0, modelFrameErr, modelErrCnt);
         end
      end
   endtask

   task automatic test_saturation();
      enterReset();
      leaveReset();
      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'b1, 1'b1, 8'($urandom), 1'b1);
         if (i == 254 || i == 299) begin
            checks++; if (err_cnt !== 8'd255 || frame_err !== 1'b1) begin errors++; $display("[TB] FAIL sat_cnt_at%0d: got cnt=%0d fe=%b expected 255 1", i, err_cnt, frame_err); end
         end
         if (i == 100) begin
            checks++; if (err_cnt !== 8'd101) begin errors++; $display("[TB] FAIL sat_cnt_mid: got %0d expected 101", err_cnt); end
         end
      end
      checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL sat_no_valid: got %b expected 0", m_valid); end
   endtask

   // Runs each scenario in order, then prints the one-line summary.
   initial begin
      clearModel();
      test_reset();
      test_single_vector();
      test_back_to_back();
      test_hold();
      test_short_frame();
      test_long_frame();
      test_reset_mid();
      test_random();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
